// File: rtl/mem_block_responder_pkg.sv
// Shared types and helpers for the block responder: FSM states, address
// geometry and block-index extraction.
package mem_pkg;

  localparam int WORD_BITS   = 32;
  localparam int OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR_WAIT,
    WR_ACK
  } state_t;

  // Upper address bits beyond the index are masked off, so addresses alias modulo DEPTH blocks.
  function automatic logic [31:0] blk_index(input logic [31:0] addr, input int unsigned idx_bits);
    logic [31:0] mask;
    mask = (32'd1 << idx_bits) - 32'd1;
    return (addr >> OFFSET_BITS) & mask;
  endfunction

endpackage

// File: rtl/mem_block_responder_ram.sv
// Block storage: one synchronous write port, one synchronous read port.
// The read register returns zero when no read is issued that edge.
module block_ram #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= re_i ? mem_q[raddr_i] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_block_responder.sv
// Single-outstanding cache block responder: serves block reads and write-backs
// after a fixed latency, with per-block valid bits so unwritten blocks read zero.
module mem_block_responder
  import mem_pkg::*;
#(
  parameter int BLOCK_BITS = 512,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [31:0]           req_addr_i,
  output logic [BLOCK_BITS-1:0] resp_data_o,
  output logic [31:0]           resp_addr_o,
  output logic                  resp_valid_o,
  input  logic                  evict_req_i,
  input  logic [31:0]           evict_addr_i,
  input  logic [BLOCK_BITS-1:0] evict_data_i,
  output logic                  evict_ack_o
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [BLOCK_BITS-1:0] data_q, data_d;
  logic [DEPTH-1:0]      blk_vld_q;

  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_addr_q, resp_addr_d;
  logic                  evict_ack_q, evict_ack_d;

  logic [IDX_W-1:0]      idx;
  logic                  ram_we;
  logic                  ram_re;

  assign idx = IDX_W'(blk_index(addr_q, IDX_W));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      blk_vld_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      evict_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      evict_ack_q  <= evict_ack_d;
      if (ram_we) begin
        blk_vld_q[idx] <= 1'b1;
      end
    end
  end

  // Captured transaction operands; pure data, no reset needed.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (evict_req_i) begin
          state_d = WR_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = evict_addr_i;
          data_d  = evict_data_i;
        end else if (req_i) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = req_addr_i;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = RD_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      WR_WAIT: begin
        if (cnt_q == '0) state_d = WR_ACK;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RD_RESP: state_d = IDLE;
      WR_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulses are computed one edge early so the outputs come straight from flops.
  always_comb begin
    resp_valid_d = (state_q == RD_WAIT) && (cnt_q == '0);
    evict_ack_d  = (state_q == WR_WAIT) && (cnt_q == '0);
    resp_addr_d  = resp_valid_d ? (addr_q & ALIGN_MASK) : '0;
    ram_we       = evict_ack_d && !rst_i;
    ram_re       = resp_valid_d && !rst_i && blk_vld_q[idx];
  end

  block_ram #(
    .WIDTH (BLOCK_BITS),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (idx),
    .wdata_i (data_q),
    .re_i    (ram_re),
    .raddr_i (idx),
    .rdata_o (resp_data_o)
  );

  assign resp_valid_o = resp_valid_q;
  assign resp_addr_o  = resp_addr_q;
  assign evict_ack_o  = evict_ack_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench for mem_block_responder: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_block_responder;
  import mem_pkg::*;

  localparam int BB  = 512;
  localparam int DP  = 256;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req, evict_req;
  logic [31:0]   req_addr, evict_addr;
  logic [BB-1:0] evict_data;
  logic [BB-1:0] resp_data;
  logic [31:0]   resp_addr;
  logic          resp_valid, evict_ack;

  logic          req1, ev1;
  logic [31:0]   req_addr1, ev_addr1;
  logic [BB-1:0] ev_data1;
  logic [BB-1:0] resp_data1;
  logic [31:0]   resp_addr1;
  logic          resp_valid1, evict_ack1;

  mem_block_responder #(.BLOCK_BITS(BB), .DEPTH(DP), .LATENCY(LAT)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr),
    .resp_data_o(resp_data), .resp_addr_o(resp_addr), .resp_valid_o(resp_valid),
    .evict_req_i(evict_req), .evict_addr_i(evict_addr), .evict_data_i(evict_data),
    .evict_ack_o(evict_ack)
  );

  mem_block_responder #(.BLOCK_BITS(BB), .DEPTH(16), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .req_addr_i(req_addr1),
    .resp_data_o(resp_data1), .resp_addr_o(resp_addr1), .resp_valid_o(resp_valid1),
    .evict_req_i(ev1), .evict_addr_i(ev_addr1), .evict_data_i(ev_data1),
    .evict_ack_o(evict_ack1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction is accepted when idle, completes LAT edges later.
  logic [BB-1:0] mmem [DP];
  bit            mw   [DP];
  bit            model_on = 1'b0;
  bit            pend     = 1'b0;
  bit            pend_wr  = 1'b0;
  int            edge_n   = 0;
  int            pend_edge = 0;
  int            free_edge = 0;
  logic [31:0]   pend_addr = '0;
  logic [BB-1:0] pend_data = '0;
  logic          exp_rv = 1'b0, exp_ack = 1'b0;
  logic [BB-1:0] exp_data = '0;
  logic [31:0]   exp_addr = '0;

  function automatic int midx(input logic [31:0] a);
    return int'((a / 32'd64) % 32'(DP));
  endfunction

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    exp_rv   <= 1'b0;
    exp_ack  <= 1'b0;
    exp_data <= '0;
    exp_addr <= '0;
    if (rst) begin
      model_on  <= 1'b1;
      pend      <= 1'b0;
      free_edge <= edge_n + 1;
      for (int i = 0; i < DP; i++) mw[i] <= 1'b0;
    end else if (pend && edge_n == pend_edge) begin
      pend      <= 1'b0;
      free_edge <= edge_n + 2;
      if (pend_wr) begin
        mmem[midx(pend_addr)] <= pend_data;
        mw[midx(pend_addr)]   <= 1'b1;
        exp_ack               <= 1'b1;
      end else begin
        exp_rv   <= 1'b1;
        exp_addr <= (pend_addr / 32'd64) * 32'd64;
        exp_data <= mw[midx(pend_addr)] ? mmem[midx(pend_addr)] : '0;
      end
    end else if (!pend && edge_n >= free_edge) begin
      if (evict_req) begin
        pend <= 1'b1; pend_wr <= 1'b1; pend_edge <= edge_n + LAT;
        pend_addr <= evict_addr; pend_data <= evict_data;
      end else if (req) begin
        pend <= 1'b1; pend_wr <= 1'b0; pend_edge <= edge_n + LAT;
        pend_addr <= req_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk_int("cyc_resp_valid", int'(resp_valid), int'(exp_rv));
      chk_int("cyc_evict_ack", int'(evict_ack), int'(exp_ack));
      chk_int("cyc_resp_addr", int'(resp_addr), int'(exp_addr));
      chk_blk("cyc_resp_data", resp_data, exp_data);
    end
  end

  task automatic wait_pulse(input bit want_ack, input int drop_at, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        req = 1'b0; evict_req = 1'b0; req_addr = 32'hFFFF_FFC0;
      end
      if (want_ack ? evict_ack : resp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=none required=pulse", want_ack ? "ack" : "resp");
    end
  endtask

  task automatic do_rd(input logic [31:0] a, output int lat);
    @(negedge clk);
    req = 1'b1; req_addr = a;
    wait_pulse(1'b0, 0, lat);
    req = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [BB-1:0] d, output int lat);
    @(negedge clk);
    evict_req = 1'b1; evict_addr = a; evict_data = d;
    @(negedge clk);
    evict_addr = ~a; evict_data = ~d;
    wait_pulse(1'b1, 0, lat);
    lat = lat + 1;
    evict_req = 1'b0;
  endtask

  logic [BB-1:0] d, p;
  int lat, lat2, acks;

  initial begin
    rst = 1'b1; req = 1'b0; evict_req = 1'b0;
    req_addr = '0; evict_addr = '0; evict_data = '0;
    req1 = 1'b0; ev1 = 1'b0; req_addr1 = '0; ev_addr1 = '0; ev_data1 = '0;
    repeat (3) @(negedge clk);
    chk_int("rst_resp_valid", int'(resp_valid), 0);
    chk_int("rst_evict_ack", int'(evict_ack), 0);
    chk_blk("rst_resp_data", resp_data, '0);
    rst = 1'b0;

    do_rd(32'h0000_1240, lat);
    chk_int("rd0_latency", lat, 5);
    chk_blk("rd0_data_zero", resp_data, '0);
    chk_int("rd0_addr", int'(resp_addr), 32'h0000_1240);

    d = '0; d[31:0] = 32'hDEAD_BEEF;
    do_wr(32'h0000_0080, d, lat);
    chk_int("wr80_latency", lat, 5);
    do_rd(32'h0000_0084, lat);
    chk_int("rd84_word0", int'(resp_data[31:0]), 32'hDEAD_BEEF);
    chk_int("rd84_addr", int'(resp_addr), 32'h0000_0080);
    chk_blk("rd84_block", resp_data, d);

    @(negedge clk);
    d = {64{8'hA5}};
    evict_req = 1'b1; evict_addr = 32'h400; evict_data = d;
    req = 1'b1; req_addr = 32'h400;
    wait_pulse(1'b1, 0, lat);
    evict_req = 1'b0;
    chk_int("sim_no_resp_at_ack", int'(resp_valid), 0);
    wait_pulse(1'b0, 0, lat2);
    req = 1'b0;
    chk_int("sim_ack_latency", lat, 5);
    chk_int("sim_rd_latency", lat2, 6);
    chk_blk("sim_rd_data_a5", resp_data, d);

    for (int j = 0; j < BB / WORD_BITS; j++) p[j*WORD_BITS +: WORD_BITS] = 32'h1000_0000 + 32'(j) * 32'h0101;
    do_wr(32'h0000_0040, p, lat);
    do_rd(32'h0000_4040, lat);
    chk_blk("alias_4040", resp_data, p);
    chk_int("alias_addr", int'(resp_addr), 32'h0000_4040);

    @(negedge clk);
    req = 1'b1; req_addr = 32'h4000_0040;
    wait_pulse(1'b0, 1, lat);
    chk_int("drop_latency", lat, 5);
    chk_blk("drop_data", resp_data, p);

    @(negedge clk);
    evict_req = 1'b1; evict_addr = 32'h100; evict_data = {BB{1'b1}};
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; evict_req = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (evict_ack) acks++;
    end
    chk_int("rst_abandon_acks", acks, 0);
    do_rd(32'h0000_0100, lat);
    chk_int("rst_rd_latency", lat, 5);
    chk_blk("rst_rd_data_zero", resp_data, '0);
    do_rd(32'h0000_0084, lat);
    chk_blk("rst_clears_valid", resp_data, '0);

    @(negedge clk);
    req1 = 1'b1; req_addr1 = 32'h0000_0040;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid1) begin lat = k; break; end
    end
    req1 = 1'b0;
    chk_int("lat1_latency", lat, 2);
    chk_int("lat1_addr", int'(resp_addr1), 32'h0000_0040);
    chk_blk("lat1_data", resp_data1, '0);
    @(negedge clk);
    chk_int("lat1_one_cycle", int'(resp_valid1), 0);
    chk_int("lat1_addr_cleared", int'(resp_addr1), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
